// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix register-file access path.
package mat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_RD,
    GNT_WR,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_RD,
    REQ_WR
  } requester_t;

  localparam logic [2:0] REG_NONE = 3'd0;

endpackage

// File: rtl/beat_counter.sv
// Burst beat counter: clears on request, counts when enabled, wraps after the last beat.
module beat_counter #(
  parameter int unsigned BEATS = 9,
  localparam int unsigned IDX_W = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] count_o,
  output logic             last_o
);

  logic [IDX_W-1:0] count_q, count_d;

  assign last_o = (count_q == IDX_W'(BEATS - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rf_access_arbiter.sv
// Grants the single-port matrix register file to RD or WR for BEATS-element bursts.
// Tie policy: round-robin, or fixed WR priority when RF_ARB_WR_PRIORITY_EN is defined.
module rf_access_arbiter
  import mat_pkg::*;
#(
  parameter int unsigned BEATS = 9,
  localparam int unsigned IDX_W = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             rd_req,
  input  logic [2:0]       rd_reg,
  input  logic             wr_req,
  input  logic [2:0]       wr_reg,
  output logic             rd_gnt,
  output logic             wr_gnt,
  output logic [2:0]       rf_sel,
  output logic [IDX_W-1:0] rf_idx,
  output logic             rf_we,
  output logic             rd_done,
  output logic             wr_done,
  output logic             req_err,
  output logic             busy
);

  arb_state_t state_q, state_d;
  requester_t last_q, last_d;
  logic [2:0] sel_q, sel_d;
  logic       err_q, err_d;

  logic             rd_ok, wr_ok, tie_rd;
  logic             cnt_en, cnt_last;
  logic [IDX_W-1:0] cnt;

  assign rd_ok = rd_req && (rd_reg != REG_NONE);
  assign wr_ok = wr_req && (wr_reg != REG_NONE);

`ifdef RF_ARB_WR_PRIORITY_EN
  assign tie_rd = 1'b0;
`else
  assign tie_rd = (last_q == REQ_WR);
`endif

  // Counting only while the owner keeps its request up; any other state clears.
  assign cnt_en = ((state_q == GNT_RD) && rd_req) || ((state_q == GNT_WR) && wr_req);

  beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk     (clk),
    .nrst    (nrst),
    .clr_i   (!cnt_en),
    .en_i    (cnt_en),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = (rd_req && (rd_reg == REG_NONE)) || (wr_req && (wr_reg == REG_NONE));
        if (rd_ok && (!wr_ok || tie_rd)) begin
          state_d = GNT_RD;
          last_d  = REQ_RD;
          sel_d   = rd_reg;
        end else if (wr_ok) begin
          state_d = GNT_WR;
          last_d  = REQ_WR;
          sel_d   = wr_reg;
        end
      end
      GNT_RD: begin
        if (!rd_req)       state_d = IDLE;
        else if (cnt_last) state_d = DONE;
      end
      GNT_WR: begin
        if (!wr_req)       state_d = IDLE;
        else if (cnt_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      last_q  <= REQ_WR;
      sel_q   <= REG_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // last_q names the burst owner while in DONE.
  assign rd_gnt  = (state_q == GNT_RD);
  assign wr_gnt  = (state_q == GNT_WR);
  assign rf_we   = (state_q == GNT_WR);
  assign rf_sel  = sel_q;
  assign rf_idx  = cnt;
  assign rd_done = (state_q == DONE) && (last_q == REQ_RD);
  assign wr_done = (state_q == DONE) && (last_q == REQ_WR);
  assign req_err = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed scoreboard bench for rf_access_arbiter (default BEATS = 9).
module tb_rf_access_arbiter;

`ifdef RF_ARB_WR_PRIORITY_EN
  localparam bit WrPri = 1'b1;
`else
  localparam bit WrPri = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       rd_req, wr_req;
  logic [2:0] rd_reg, wr_reg;
  logic       rd_gnt, wr_gnt, rf_we, rd_done, wr_done, req_err, busy;
  logic [2:0] rf_sel;
  logic [3:0] rf_idx;

  int vectors     = 0;
  int miscompares = 0;

  logic [13:0] exp_q[$];
  logic [13:0] obs;
  bit          first_wr;

  assign obs = {rd_gnt, wr_gnt, rf_sel, rf_idx, rf_we, rd_done, wr_done, req_err, busy};

  always #5 clk = ~clk;

  rf_access_arbiter #(
    .BEATS (9)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .rd_req  (rd_req),
    .rd_reg  (rd_reg),
    .wr_req  (wr_req),
    .wr_reg  (wr_reg),
    .rd_gnt  (rd_gnt),
    .wr_gnt  (wr_gnt),
    .rf_sel  (rf_sel),
    .rf_idx  (rf_idx),
    .rf_we   (rf_we),
    .rd_done (rd_done),
    .wr_done (wr_done),
    .req_err (req_err),
    .busy    (busy)
  );

  function automatic logic [13:0] ev(bit rg, bit wg, logic [2:0] sel, logic [3:0] idx, bit we,
                                     bit rdd, bit wrd, bit err, bit bsy);
    return {rg, wg, sel, idx, we, rdd, wrd, err, bsy};
  endfunction

  task automatic chk(string tag, logic [13:0] got, logic [13:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n cycles, comparing each post-edge output against the next queued entry.
  task automatic run(int n, string tag);
    logic [13:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 14'h3fff;
      chk(tag, obs, e);
    end
  endtask

  task automatic push_idle(logic [2:0] sel, bit err);
    exp_q.push_back(ev(1'b0, 1'b0, sel, 4'd0, 1'b0, 1'b0, 1'b0, err, 1'b0));
  endtask

  task automatic push_grant(bit wr, logic [2:0] sel, int from, int to, bit err0);
    for (int i = from; i <= to; i++)
      exp_q.push_back(ev(!wr, wr, sel, 4'(i), wr, 1'b0, 1'b0, (i == from) && err0, 1'b1));
  endtask

  // Full burst plus DONE, then the requester releases and one IDLE cycle is checked.
  task automatic burst_release(bit wr, logic [2:0] sel, bit err0, bit drop_both, string tag);
    push_grant(wr, sel, 0, 8, err0);
    exp_q.push_back(ev(1'b0, 1'b0, sel, 4'd0, 1'b0, !wr, wr, 1'b0, 1'b1));
    run(10, tag);
    if (wr) wr_req = 1'b0;
    else    rd_req = 1'b0;
    if (drop_both) begin
      rd_req = 1'b0;
      wr_req = 1'b0;
    end
    push_idle(sel, 1'b0);
    run(1, {tag, "_idle"});
  endtask

  initial begin
    nrst   = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    rd_reg = 3'd0;
    wr_reg = 3'd0;
    first_wr = WrPri;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs, 14'd0);
    nrst = 1'b1;

    // RD alone.
    rd_req = 1'b1;
    rd_reg = 3'd3;
    burst_release(1'b0, 3'd3, 1'b0, 1'b0, "rd_only");

    // Fresh tie after reset: both bursts served back to back.
    nrst = 1'b0;
    #1;
    chk("reset_again", obs, 14'd0);
    nrst   = 1'b1;
    rd_req = 1'b1;
    rd_reg = 3'd2;
    wr_req = 1'b1;
    wr_reg = 3'd5;
    burst_release(first_wr, first_wr ? 3'd5 : 3'd2, 1'b0, 1'b0, "tie_first");
    burst_release(!first_wr, first_wr ? 3'd2 : 3'd5, 1'b0, 1'b0, "tie_second");

    // Second tie, then a third to show alternation (WR wins both under priority).
    rd_req = 1'b1;
    wr_req = 1'b1;
    burst_release(first_wr, first_wr ? 3'd5 : 3'd2, 1'b0, 1'b1, "tie_repeat");
    rd_req = 1'b1;
    wr_req = 1'b1;
    burst_release(1'b1, 3'd5, 1'b0, 1'b1, "tie_third");

    // Invalid register on WR only: error flagged, never granted.
    wr_req = 1'b1;
    wr_reg = 3'd0;
    repeat (3) push_idle(3'd5, 1'b1);
    run(3, "wr_reg0");
    wr_req = 1'b0;
    push_idle(3'd5, 1'b0);
    run(1, "wr_reg0_clear");

    // One invalid, one valid: valid one granted with error on the first grant cycle.
    rd_req = 1'b1;
    rd_reg = 3'd0;
    wr_req = 1'b1;
    wr_reg = 3'd4;
    burst_release(1'b1, 3'd4, 1'b1, 1'b1, "mixed_valid");

    // Abort RD at index 4 with WR pending.
    rd_req = 1'b1;
    rd_reg = 3'd6;
    push_grant(1'b0, 3'd6, 0, 4, 1'b0);
    run(1, "abort_rd");
    wr_req = 1'b1;
    wr_reg = 3'd7;
    run(4, "abort_rd");
    rd_req = 1'b0;
    rd_reg = 3'd1;
    push_idle(3'd6, 1'b0);
    run(1, "abort_idle");
    push_grant(1'b1, 3'd7, 0, 6, 1'b0);
    run(7, "wr_after_abort");

    // Asynchronous reset at index 6 of the WR burst.
    nrst = 1'b0;
    #1;
    chk("async_reset", obs, 14'd0);
    @(posedge clk);
    #1;
    rd_req = 1'b1;
    rd_reg = 3'd1;
    wr_reg = 3'd2;
    nrst   = 1'b1;
    push_grant(first_wr, first_wr ? 3'd2 : 3'd1, 0, 1, 1'b0);
    run(2, "tie_after_reset");

    rd_req = 1'b0;
    wr_req = 1'b0;
    chk("scoreboard_drained", 14'(exp_q.size()), 14'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
